// File: rtl/dram_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM (m0 = CPU, m1 = loader/DMA).
// Latency: req seen in IDLE -> one ACCESS cycle -> one ACK cycle; 3 cycles minimum per transaction.
// Backpressure: a pending request holds its stall (m0) until ack; the losing master simply waits.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   m0_* / m1_*          master ports: req/we/addr/wdata/sel in, ack/rdata out; m0_stall = m0_req & ~m0_ack
//   ram_*                RAM control, address, write data and byte enables; ram_rdata registered in RAM
//   busy                 high whenever a transaction is in flight
module dram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_stall,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_sel,
  input  logic [DATA_W-1:0]   ram_rdata,

  output logic                busy
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state;
  logic       grant;       // 0 = m0, 1 = m1; valid from ACCESS through ACK
  logic       last_grant;
  logic [7:0] wait_cnt;    // lost arbitrations of m1 since its last grant
  logic       ce_q;        // registered ACCESS flag
  logic       ack_q;       // registered ACK flag
  logic       xfer_we;     // direction of the transaction in flight
  logic       win;

  // Winner if a grant happens this cycle. With one requester it wins outright;
  // on a tie the policy decides.
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) begin
      if (FIXED_PRIO) begin
        win = (wait_cnt >= MAX_WAIT_C);
      end else begin
        win = ~last_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= 8'd0;
      ce_q       <= 1'b0;
      ack_q      <= 1'b0;
      xfer_we    <= 1'b0;
    end else begin
      ce_q  <= 1'b0;
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state      <= ACCESS;
            grant      <= win;
            last_grant <= win;
            xfer_we    <= win ? m1_we : m0_we;
            ce_q       <= 1'b1;
            if (win) begin
              wait_cnt <= 8'd0;
            end else if (m1_req && (wait_cnt != 8'hFF)) begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        ACCESS: begin
          state <= ACK;
          ack_q <= 1'b1;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Masters hold their inputs stable until ack, so the RAM side is a plain
  // mux of the granted master, forced to zero outside ACCESS.
  assign ram_ce    = ce_q;
  assign ram_we    = ce_q & (grant ? m1_we : m0_we);
  assign ram_addr  = ce_q ? (grant ? m1_addr  : m0_addr)  : '0;
  assign ram_wdata = ce_q ? (grant ? m1_wdata : m0_wdata) : '0;
  assign ram_sel   = ce_q ? (grant ? m1_sel   : m0_sel)   : '0;

  // The RAM registers its read data, so it is valid exactly in the ACK cycle.
  assign m0_ack   = ack_q & ~grant;
  assign m1_ack   = ack_q &  grant;
  assign m0_rdata = (m0_ack && !xfer_we) ? ram_rdata : '0;
  assign m1_rdata = (m1_ack && !xfer_we) ? ram_rdata : '0;

  assign m0_stall = m0_req & ~m0_ack;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: round-robin instance; index 1: fixed priority with MAX_WAIT=2.
  logic        rst       [2];
  logic        m0_req    [2];
  logic        m0_we     [2];
  logic [31:0] m0_addr   [2];
  logic [31:0] m0_wdata  [2];
  logic [3:0]  m0_sel    [2];
  logic        m0_ack    [2];
  logic [31:0] m0_rdata  [2];
  logic        m0_stall  [2];
  logic        m1_req    [2];
  logic        m1_we     [2];
  logic [31:0] m1_addr   [2];
  logic [31:0] m1_wdata  [2];
  logic [3:0]  m1_sel    [2];
  logic        m1_ack    [2];
  logic [31:0] m1_rdata  [2];
  logic        ram_ce    [2];
  logic        ram_we    [2];
  logic [31:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [3:0]  ram_sel   [2];
  logic [31:0] ram_rdata [2];
  logic        busy      [2];

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst(rst[0]),
    .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_sel(m0_sel[0]), .m0_ack(m0_ack[0]), .m0_rdata(m0_rdata[0]), .m0_stall(m0_stall[0]),
    .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_sel(m1_sel[0]), .m1_ack(m1_ack[0]), .m1_rdata(m1_rdata[0]),
    .ram_ce(ram_ce[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_sel(ram_sel[0]), .ram_rdata(ram_rdata[0]), .busy(busy[0])
  );

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1), .MAX_WAIT(2)) dut_fx (
    .clk(clk), .rst(rst[1]),
    .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_sel(m0_sel[1]), .m0_ack(m0_ack[1]), .m0_rdata(m0_rdata[1]), .m0_stall(m0_stall[1]),
    .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_sel(m1_sel[1]), .m1_ack(m1_ack[1]), .m1_rdata(m1_rdata[1]),
    .ram_ce(ram_ce[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_sel(ram_sel[1]), .ram_rdata(ram_rdata[1]), .busy(busy[1])
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Registered single-port RAM attached to each DUT.
  logic [31:0] ram_mem [2][256];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_ce[k]) begin
        ram_rdata[k] <= ram_mem[k][ram_addr[k][9:2]];
        if (ram_we[k]) ram_mem[k][ram_addr[k][9:2]] = merge(ram_mem[k][ram_addr[k][9:2]], ram_wdata[k], ram_sel[k]);
      end
    end
  end

  // ---------------- Behavioural model ----------------
  // A transaction is a timestamp: decided in idle cycle t, RAM access in t+1,
  // ack in t+2. The model keeps its own copy of memory.
  bit          started = 1'b0;
  int          cyc = 0;
  bit          m_act   [2];
  int          m_start [2];
  bit          m_win   [2];
  bit          m_lg    [2];
  int          m_wc    [2];
  bit          m_wr    [2];
  logic [31:0] m_rd    [2];
  logic [31:0] mm      [2][256];

  bit          e_acc, e_ak, e_we, e_ack0, e_ack1, nw;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
  logic [3:0]  e_sel;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        e_acc   = m_act[k] && (cyc == m_start[k] + 1);
        e_ak    = m_act[k] && (cyc == m_start[k] + 2);
        e_we    = e_acc && (m_win[k] ? m1_we[k] : m0_we[k]);
        e_addr  = e_acc ? (m_win[k] ? m1_addr[k]  : m0_addr[k])  : 32'h0;
        e_wdata = e_acc ? (m_win[k] ? m1_wdata[k] : m0_wdata[k]) : 32'h0;
        e_sel   = e_acc ? (m_win[k] ? m1_sel[k]   : m0_sel[k])   : 4'h0;
        if (e_acc) begin
          m_wr[k] = e_we;
          if (e_we) mm[k][e_addr[9:2]] = merge(mm[k][e_addr[9:2]], e_wdata, e_sel);
          else      m_rd[k] = mm[k][e_addr[9:2]];
        end
        e_ack0 = e_ak && !m_win[k];
        e_ack1 = e_ak &&  m_win[k];
        e_rd0  = (e_ack0 && !m_wr[k]) ? m_rd[k] : 32'h0;
        e_rd1  = (e_ack1 && !m_wr[k]) ? m_rd[k] : 32'h0;

        chk("ram_ce",    k, ram_ce[k],    e_acc);
        chk("ram_we",    k, ram_we[k],    e_we);
        chk("ram_addr",  k, ram_addr[k],  e_addr);
        chk("ram_wdata", k, ram_wdata[k], e_wdata);
        chk("ram_sel",   k, ram_sel[k],   e_sel);
        chk("m0_ack",    k, m0_ack[k],    e_ack0);
        chk("m1_ack",    k, m1_ack[k],    e_ack1);
        chk("m0_rdata",  k, m0_rdata[k],  e_rd0);
        chk("m1_rdata",  k, m1_rdata[k],  e_rd1);
        chk("m0_stall",  k, m0_stall[k],  m0_req[k] & ~e_ack0);
        chk("busy",      k, busy[k],      e_acc | e_ak);

        // What the coming clock edge does.
        if (rst[k]) begin
          m_act[k] = 1'b0;
          m_lg[k]  = 1'b1;
          m_wc[k]  = 0;
        end else if (!e_acc && !e_ak && (m0_req[k] || m1_req[k])) begin
          if (m0_req[k] && m1_req[k]) nw = (k == 1) ? (m_wc[k] >= 2) : !m_lg[k];
          else                        nw = m1_req[k];
          if (nw)                            m_wc[k] = 0;
          else if (m1_req[k] && m_wc[k] < 255) m_wc[k]++;
          m_lg[k]    = nw;
          m_win[k]   = nw;
          m_act[k]   = 1'b1;
          m_start[k] = cyc;
        end
      end
    end
    cyc++;
  end

  // ---------------- Stimulus ----------------
  task automatic drive(input int k, input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    if (m == 0) begin
      m0_req[k] = req; m0_we[k] = we; m0_addr[k] = addr; m0_wdata[k] = wdata; m0_sel[k] = sel;
    end else begin
      m1_req[k] = req; m1_we[k] = we; m1_addr[k] = addr; m1_wdata[k] = wdata; m1_sel[k] = sel;
    end
  endtask

  task automatic wait_ack(input int k, input int m, output logic [31:0] rd, output int stalls, output int n);
    bit got;
    got = 1'b0; stalls = 0; n = 0; rd = 32'h0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if ((m == 0) ? m0_ack[k] : m1_ack[k]) begin
        got = 1'b1;
        rd  = (m == 0) ? m0_rdata[k] : m1_rdata[k];
      end else if (m == 0 && m0_stall[k]) begin
        stalls++;
      end
    end
    chk("ack_seen", k, 32'(got), 32'd1);
  endtask

  task automatic txn(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, output logic [31:0] rd, output int stalls, output int n);
    @(posedge clk); #1;
    drive(0, m, 1'b1, we, addr, wdata, sel);
    wait_ack(0, m, rd, stalls, n);
    @(posedge clk); #1;
    drive(0, m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Both masters hold read requests until n acks; returns grant order (1 = m1), oldest first.
  task automatic both_hold(input int k, input int n, output logic [7:0] ord, output int got);
    int last;
    ord = 8'h0; got = 0; last = 0;
    @(posedge clk); #1;
    drive(k, 0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    drive(k, 1, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    for (int i = 0; i < 60 && got < n; i++) begin
      @(negedge clk);
      if (m0_ack[k] || m1_ack[k]) begin
        chk("one_ack_only", k, 32'(m0_ack[k] & m1_ack[k]), 32'd0);
        if (got > 0) chk("ack_spacing", k, i - last, 3);
        ord  = {ord[6:0], m1_ack[k]};
        last = i;
        got++;
      end
    end
    @(posedge clk); #1;
    drive(k, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(k, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic preload(input int k, input logic [31:0] addr, input logic [31:0] data);
    ram_mem[k][addr[9:2]] = data;
    mm[k][addr[9:2]]      = data;
  endtask

  logic [31:0] rd, rd1, rd2;
  logic [7:0]  ord;
  int          stalls, n, n2, got;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      drive(k, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(k, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      m_act[k] = 1'b0; m_lg[k] = 1'b1; m_wc[k] = 0; m_start[k] = 0;
      m_win[k] = 1'b0; m_wr[k] = 1'b0; m_rd[k] = 32'h0;
      for (int a = 0; a < 256; a++) begin
        ram_mem[k][a] = 32'h0;
        mm[k][a]      = 32'h0;
      end
    end
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("reset_busy",   0, 32'(busy[0]),   32'd0);
    chk("reset_ram_ce", 1, 32'(ram_ce[1]), 32'd0);

    // Round-robin: first tie after reset goes to m0, then alternates.
    both_hold(0, 4, ord, got);
    chk("rr_count", 0, got, 4);
    chk("rr_order", 0, 32'(ord), 32'h05);

    // m0 read of a preloaded word.
    preload(0, 32'h10, 32'h12345678);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, stalls, n);
    chk("m0_read_data",    0, rd, 32'h12345678);
    chk("m0_read_stalls",  0, stalls, 2);
    chk("m0_read_latency", 0, n, 3);

    // m1 full write, then m0 reads it back.
    txn(1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, stalls, n);
    chk("m1_write_rdata_zero", 0, rd, 32'h0);
    chk("m1_write_ram",        0, ram_mem[0][8], 32'hDEADBEEF);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, stalls, n);
    chk("readback_deadbeef",   0, rd, 32'hDEADBEEF);

    // Partial write: bytes 0 and 2 only.
    txn(1, 1'b1, 32'h20, 32'h11223344, 4'b0101, rd, stalls, n);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, stalls, n);
    chk("partial_write", 0, rd, 32'hDE22BE44);

    // Reset during the ACCESS cycle of an m0 write.
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst_access_ce",  0, 32'(ram_ce[0]), 32'd1);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_no_ack",     0, 32'(m0_ack[0]), 32'd0);
    chk("rst_busy",       0, 32'(busy[0]), 32'd0);
    chk("rst_write_done", 0, ram_mem[0][12], 32'hCAFEF00D);
    txn(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, rd, stalls, n);
    txn(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, stalls, n);
    chk("reissue_readback", 0, rd, 32'h0BADF00D);

    // m0 holds req across two transactions, address changes after the first ack.
    preload(0, 32'h0, 32'hA0A0A0A0);
    preload(0, 32'h4, 32'hB1B1B1B1);
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_ack(0, 0, rd1, stalls, n);
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    wait_ack(0, 0, rd2, stalls, n2);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("hold_first",   0, rd1, 32'hA0A0A0A0);
    chk("hold_second",  0, rd2, 32'hB1B1B1B1);
    chk("hold_spacing", 0, n2, 3);

    // Fixed priority, MAX_WAIT=2: m1 forced in every third grant.
    both_hold(1, 6, ord, got);
    chk("fx_count", 1, got, 6);
    chk("fx_order", 1, 32'(ord), 32'h09);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_mis);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port data RAM.
- Port m0 is the CPU data-memory port; port m1 is a secondary master (loader/DMA).
- Grants one master per transaction and drives the RAM control, address and data lines.
- Returns read data with a one-cycle ack and produces a stall to the CPU pipeline while its request is pending.

Parameters:
- ADDR_W, 32, address width (matches data address bus)
- DATA_W, 32, data width; byte-select width is DATA_W/8
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 wins ties, subject to starvation limit
- MAX_WAIT, 4, FIXED_PRIO=1 only: lost arbitrations after which m1 is forced to win (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  m0 transaction request; hold until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  write data
- m0_sel  in  DATA_W/8  byte enables
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid only while m0_ack=1
- m0_stall  out  1  m0_req & ~m0_ack, combinational; feeds CPU stall
- m1_req, m1_we, m1_addr, m1_wdata, m1_sel, m1_ack, m1_rdata  same widths and rules as m0
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_sel  out  DATA_W/8  RAM byte enables
- ram_rdata  in  DATA_W  RAM read data, registered in RAM, valid the cycle after ce
- busy  out  1  state != IDLE

Behaviour:
- FSM states:
  - IDLE: requests sampled here only.
    - If any req is high at a clock edge, latch the winner into grant, go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS (1 cycle):
    - ram_ce=1; ram_we/addr/wdata/sel are mux of the granted master's inputs.
    - Write commits in RAM at the end of this cycle; read data is captured by RAM.
    - Go to ACK.
  - ACK (1 cycle):
    - Granted master's ack=1.
    - Its rdata = ram_rdata if the transaction was a read, else 0.
    - Go to IDLE.
- Latency: req high before edge E0 in IDLE -> ACCESS after E0 -> ack high in the cycle after E1. Minimum 3 cycles per transaction; no back-to-back ACCESS.
- Masters must hold req, we, addr, wdata, sel stable from req until ack. Inputs are not registered.
- A master still holding req in the IDLE cycle after its ack is treated as a new request. A master wanting one transaction drops req the cycle after ack.
- Arbitration, round-robin (FIXED_PRIO=0):
  - Single requester wins.
  - Both requesting: the master not in last_grant wins.
  - last_grant updates on each grant; reset value 1, so m0 wins the first tie.
- Arbitration, fixed (FIXED_PRIO=1):
  - m0 wins ties unless wait_cnt >= MAX_WAIT, in which case m1 wins.
  - wait_cnt (8-bit, saturating) increments each time m1 requests in IDLE and loses.
  - wait_cnt clears when m1 is granted.
- Outputs outside ACCESS: ram_ce, ram_we, ram_addr, ram_wdata, ram_sel = 0.
- Outputs outside ACK: both acks = 0, both rdata = 0.
- Reset values: state=IDLE, grant=0, last_grant=1, wait_cnt=0. Every output is 0 during and after reset, except m0_stall, which follows m0_req since ack=0.
- Reset mid-operation:
  - rst at the edge ending ACCESS: the RAM write/read still occurs because ram_ce was already driven; the FSM goes to IDLE and no ack is issued.
  - rst during ACK: the ack is visible that cycle; the FSM goes to IDLE.
  - The master must reissue after reset.
- Only the granted master ever sees ack; the losing master's ack stays 0 and its stall stays high.

Test Plan:
- m0 read, m0_addr=0x10, RAM word 0x12345678:
  - ram_ce=1, ram_we=0, ram_addr=0x10 for exactly one cycle.
  - Next cycle m0_ack=1, m0_rdata=0x12345678.
  - m0_stall=1 for 2 cycles before ack.
- m1 write, addr=0x20, wdata=0xDEADBEEF, sel=4'b1111:
  - One ACCESS cycle with ram_we=1, then m1_ack pulse.
  - A following m0 read of 0x20 returns 0xDEADBEEF.
- FIXED_PRIO=0, both masters hold req continuously:
  - Grants alternate m0, m1, m0, m1.
  - Acks 3 cycles apart; no ack ever high for both masters.
- FIXED_PRIO=1, MAX_WAIT=2, both hold req continuously:
  - Grant order m0, m0, m1, m0, m0, m1.
  - wait_cnt returns to 0 after each m1 grant.
- rst pulsed during the ACCESS cycle of an m0 write:
  - The write reaches RAM; m0_ack never asserts; busy=0 after reset.
  - Reissued write completes normally.
- m0 holds req across two transactions (addr 0x0 then 0x4, changed the cycle after the first ack):
  - Two acks exactly 3 cycles apart; RAM sees address 0x0 then 0x4.
